// File: rtl/wave_fetch_sched.sv
// Frame-fetch scheduler: issues one PSRAM read burst per display column each frame,
// tracks returning beats, and applies keypad pan/zoom to the frame base and pitch.
module wave_fetch_sched #(
  parameter int NUM_BURSTS      = 640,
  parameter int BURST_BEATS     = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ZOOM_MAX        = 7,
  parameter int PAN_COLS        = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        psram_ready,
  input  logic        vsync,
  input  logic        key_left,
  input  logic        key_right,
  input  logic        key_zoom_in,
  input  logic        key_zoom_out,
  output logic [24:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic        rvalid,
  output logic [2:0]  zoom,
  output logic [24:0] base_addr,
  output logic        frame_done,
  output logic        overrun,
  output logic        rsp_error
);

  localparam logic [9:0] LAST_ISSUE_C = 10'(NUM_BURSTS - 1);
  localparam logic [1:0] LAST_BEAT_C  = 2'(BURST_BEATS - 1);
  localparam logic [2:0] MAX_OUT_C    = 3'(MAX_OUTSTANDING);
  localparam logic [2:0] ZOOM_MAX_C   = 3'(ZOOM_MAX);
  localparam int         PAN_SHIFT    = $clog2(PAN_COLS);

  typedef enum logic [1:0] {
    ST_STARTUP = 2'd0,
    ST_IDLE    = 2'd1,
    ST_ISSUE   = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  function automatic logic [24:0] step_of(input logic [2:0] z);
    step_of = 25'd8 << z;
  endfunction

  state_t      state_r, state_s;
  logic        vsync_meta_r, vsync_sync_r, vsync_prev_r, vsync_rise_r;
  logic [24:0] araddr_r, araddr_s;
  logic        arvalid_r, arvalid_s;
  logic [2:0]  zoom_r, zoom_s;
  logic [24:0] base_r, base_s;
  logic        frame_done_r, frame_done_s;
  logic        overrun_r, rsp_error_r;
  logic [9:0]  issued_r, issued_s;
  logic [2:0]  outstanding_r, outstanding_s;
  logic [1:0]  beat_r, beat_s;
  logic [3:0]  pend_r, pend_s;
  logic [3:0]  key_s, apply_s;
  logic [24:0] step_s, pan_s;
  logic        hs_s, orphan_s, retire_s;

  assign key_s    = {key_zoom_out, key_zoom_in, key_right, key_left};
  assign step_s   = step_of(zoom_r);
  assign hs_s     = arvalid_r & arready;
  assign orphan_s = rvalid & (outstanding_r == 3'd0);
  assign retire_s = rvalid & ~orphan_s & (beat_r == LAST_BEAT_C);

  // Vsync synchroniser with a registered rising-edge pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_meta_r <= 1'b0;
      vsync_sync_r <= 1'b0;
      vsync_prev_r <= 1'b0;
      vsync_rise_r <= 1'b0;
    end else begin
      vsync_meta_r <= vsync;
      vsync_sync_r <= vsync_meta_r;
      vsync_prev_r <= vsync_sync_r;
      vsync_rise_r <= vsync_sync_r & ~vsync_prev_r;
    end
  end

  // Fetch FSM next state, request accumulator and burst/beat bookkeeping
  always_comb begin
    state_s       = state_r;
    araddr_s      = araddr_r;
    issued_s      = issued_r;
    outstanding_s = outstanding_r;
    beat_s        = beat_r;
    if (!psram_ready) begin
      state_s       = ST_STARTUP;
      issued_s      = 10'd0;
      outstanding_s = 3'd0;
      beat_s        = 2'd0;
    end else begin
      if (rvalid && !orphan_s) beat_s = beat_r + 2'd1;
      else beat_s = beat_r;
      if (hs_s && !retire_s) outstanding_s = outstanding_r + 3'd1;
      else if (retire_s && !hs_s) outstanding_s = outstanding_r - 3'd1;
      else outstanding_s = outstanding_r;
      case (state_r)
        ST_STARTUP: state_s = ST_IDLE;
        ST_IDLE: begin
          if (vsync_rise_r) begin
            araddr_s = base_r;
            issued_s = 10'd0;
            state_s  = ST_ISSUE;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (hs_s) begin
            issued_s = issued_r + 10'd1;
            araddr_s = araddr_r + step_s;
            if (issued_r == LAST_ISSUE_C) state_s = ST_DRAIN;
            else state_s = ST_ISSUE;
          end else begin
            state_s = ST_ISSUE;
          end
        end
        ST_DRAIN: begin
          if (outstanding_r == 3'd0) state_s = ST_IDLE;
          else state_s = ST_DRAIN;
        end
        default: state_s = ST_STARTUP;
      endcase
    end
    // Outputs are registered from next-state values so they line up with the state they describe
    arvalid_s    = (state_s == ST_ISSUE) && (outstanding_s < MAX_OUT_C);
    frame_done_s = (state_s == ST_DRAIN) && (outstanding_s == 3'd0);
  end

  // Keypad: apply in IDLE (zoom first, then pan with the new step), otherwise hold pending
  always_comb begin
    pend_s  = pend_r;
    zoom_s  = zoom_r;
    base_s  = base_r;
    apply_s = 4'd0;
    pan_s   = 25'd0;
    if (state_r == ST_IDLE) begin
      apply_s = pend_r | key_s;
      pend_s  = 4'd0;
      if (apply_s[2] && !apply_s[3] && (zoom_r != ZOOM_MAX_C)) zoom_s = zoom_r + 3'd1;
      else if (apply_s[3] && !apply_s[2] && (zoom_r != 3'd0)) zoom_s = zoom_r - 3'd1;
      else zoom_s = zoom_r;
      pan_s = step_of(zoom_s) << PAN_SHIFT;
      if (apply_s[0] && !apply_s[1]) base_s = (base_r >= pan_s) ? (base_r - pan_s) : 25'd0;
      else if (apply_s[1] && !apply_s[0]) base_s = base_r + pan_s;
      else base_s = base_r;
    end else begin
      pend_s = pend_r | key_s;
    end
  end

  // State, counters, outputs and sticky error flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_STARTUP;
      araddr_r      <= 25'd0;
      arvalid_r     <= 1'b0;
      zoom_r        <= 3'd0;
      base_r        <= 25'd0;
      frame_done_r  <= 1'b0;
      overrun_r     <= 1'b0;
      rsp_error_r   <= 1'b0;
      issued_r      <= 10'd0;
      outstanding_r <= 3'd0;
      beat_r        <= 2'd0;
      pend_r        <= 4'd0;
    end else begin
      state_r       <= state_s;
      araddr_r      <= araddr_s;
      arvalid_r     <= arvalid_s;
      zoom_r        <= zoom_s;
      base_r        <= base_s;
      frame_done_r  <= frame_done_s;
      overrun_r     <= overrun_r | (vsync_rise_r & (state_r != ST_IDLE));
      rsp_error_r   <= rsp_error_r | orphan_s;
      issued_r      <= issued_s;
      outstanding_r <= outstanding_s;
      beat_r        <= beat_s;
      pend_r        <= pend_s;
    end
  end

  assign araddr     = araddr_r;
  assign arvalid    = arvalid_r;
  assign zoom       = zoom_r;
  assign base_addr  = base_r;
  assign frame_done = frame_done_r;
  assign overrun    = overrun_r;
  assign rsp_error  = rsp_error_r;

endmodule
